// File: rtl/systolic_feed_ctrl_pkg.sv
// Shared constants and state encoding for the systolic activation feed sequencer.
package systolic_feed_ctrl_pkg;

   localparam int DEF_WORD_WIDTH = 80;
   localparam int DEF_DATA_WIDTH = 8;
   // One flush word per skew stage so the last lane drains completely.
   localparam int SKEW_DEPTH     = DEF_WORD_WIDTH / DEF_DATA_WIDTH - 1;
   localparam int FLUSH_CNT_W    = $clog2(SKEW_DEPTH + 1);

   typedef enum logic [1:0] {
      FEED_IDLE  = 2'd0,
      FEED_RUN   = 2'd1,
      FEED_FLUSH = 2'd2,
      FEED_DONE  = 2'd3
   } feed_state_e;

endpackage

// File: rtl/systolic_feed_ctrl.sv
// Streams len words from the activation buffer into the skew stage, then flushes
// the skew chain with zero words and pulses done_o.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// FEED_IDLE  | waiting for start_i; captures base/len on start
// FEED_RUN   | issuing buffer reads and forwarding returned words
// FEED_FLUSH | driving SKEW_DEPTH zero words through the skew chain
// FEED_DONE  | one-cycle done_o pulse, back to idle
module systolic_feed_ctrl
   import systolic_feed_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  logic [ADDR_WIDTH:0]   len_i,
   input  logic                  stall_i,
   output logic                  rd_en_o,
   output logic [ADDR_WIDTH-1:0] rd_addr_o,
   input  logic [WORD_WIDTH-1:0] rd_data_i,
   output logic                  skew_en_o,
   output logic [WORD_WIDTH-1:0] skew_word_o,
   output logic                  busy_o,
   output logic                  done_o
);

   feed_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0]   base_q;
   logic [ADDR_WIDTH:0]     len_q;
   logic [ADDR_WIDTH:0]     issued_q;
   logic [ADDR_WIDTH:0]     sent_q;
   logic [FLUSH_CNT_W-1:0]  flush_q;
   logic                    rd_vld_q;
   logic                    hold_vld_q;
   logic [WORD_WIDTH-1:0]   hold_q;

   always_comb begin
      state_d     = state_q;
      rd_en_o     = 1'b0;
      rd_addr_o   = '0;
      skew_en_o   = 1'b0;
      skew_word_o = '0;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      case (state_q)
         FEED_IDLE: begin
            if (start_i) state_d = (len_i == '0) ? FEED_DONE : FEED_RUN;
         end
         FEED_RUN: begin
            busy_o    = 1'b1;
            rd_en_o   = !stall_i && (issued_q < len_q);
            rd_addr_o = base_q + issued_q[ADDR_WIDTH-1:0];
            skew_en_o = !stall_i && (hold_vld_q || rd_vld_q);
            if (skew_en_o) begin
               // The held word is always older than anything on rd_data_i.
               skew_word_o = hold_vld_q ? hold_q : rd_data_i;
               if (sent_q + 1'b1 == len_q) state_d = FEED_FLUSH;
            end
         end
         FEED_FLUSH: begin
            busy_o    = 1'b1;
            skew_en_o = !stall_i;
            if (skew_en_o && flush_q == FLUSH_CNT_W'(SKEW_DEPTH - 1)) state_d = FEED_DONE;
         end
         FEED_DONE: begin
            done_o  = 1'b1;
            state_d = FEED_IDLE;
         end
         default: state_d = FEED_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= FEED_IDLE;
         base_q     <= '0;
         len_q      <= '0;
         issued_q   <= '0;
         sent_q     <= '0;
         flush_q    <= '0;
         rd_vld_q   <= 1'b0;
         hold_vld_q <= 1'b0;
         hold_q     <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            FEED_IDLE: begin
               if (start_i) begin
                  base_q     <= base_addr_i;
                  len_q      <= len_i;
                  issued_q   <= '0;
                  sent_q     <= '0;
                  flush_q    <= '0;
                  rd_vld_q   <= 1'b0;
                  hold_vld_q <= 1'b0;
               end
            end
            FEED_RUN: begin
               rd_vld_q <= rd_en_o;
               if (rd_en_o)   issued_q <= issued_q + 1'b1;
               if (skew_en_o) sent_q   <= sent_q + 1'b1;
               // Reads stop while stalled, so at most one returning word needs parking.
               if (stall_i && rd_vld_q) begin
                  hold_q     <= rd_data_i;
                  hold_vld_q <= 1'b1;
               end else if (skew_en_o && hold_vld_q) begin
                  hold_vld_q <= 1'b0;
               end
            end
            FEED_FLUSH: begin
               rd_vld_q <= 1'b0;
               if (skew_en_o) flush_q <= flush_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Scoreboard bench for systolic_feed_ctrl: driver pushes expected reads/words,
// a negedge monitor pops and compares and tracks busy/done with a cycle-budget model.
module tb_systolic_feed_ctrl;
   import systolic_feed_ctrl_pkg::*;

   localparam int AW    = 8;
   localparam int LW    = AW + 1;
   localparam int WW    = DEF_WORD_WIDTH;
   localparam int DEPTH = 1 << AW;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          start_i;
   logic [AW-1:0] base_addr_i;
   logic [LW-1:0] len_i;
   logic          stall_i;
   logic          rd_en_o;
   logic [AW-1:0] rd_addr_o;
   logic [WW-1:0] rd_data_i;
   logic          skew_en_o;
   logic [WW-1:0] skew_word_o;
   logic          busy_o;
   logic          done_o;

   systolic_feed_ctrl #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .start_i     (start_i),
      .base_addr_i (base_addr_i),
      .len_i       (len_i),
      .stall_i     (stall_i),
      .rd_en_o     (rd_en_o),
      .rd_addr_o   (rd_addr_o),
      .rd_data_i   (rd_data_i),
      .skew_en_o   (skew_en_o),
      .skew_word_o (skew_word_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   always #5 clk_i = ~clk_i;

   logic [WW-1:0] mem [DEPTH];
   logic [AW-1:0] exp_addr_q [$];
   logic [WW-1:0] exp_word_q [$];

   int tests = 0;
   int fails = 0;
   int rd_cnt = 0;
   int skew_cnt = 0;
   int done_cnt = 0;
   int ph = 0;   // 0 idle, 1 busy, 2 done cycle
   int rem = 0;  // non-stalled busy cycles still owed

   function automatic logic [WW-1:0] rand_word();
      logic [95:0] w;
      w = {$urandom(), $urandom(), $urandom()};
      return w[WW-1:0];
   endfunction

   task automatic chk(input string name, input logic [WW-1:0] got, input logic [WW-1:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Activation buffer: one-cycle read latency, garbage when not read.
   always @(posedge clk_i) rd_data_i <= rd_en_o ? mem[rd_addr_o] : rand_word();

   always @(negedge clk_i) begin
      if (!rst_ni) begin
         chk("reset_ctrl_outputs", WW'({rd_en_o, rd_addr_o, skew_en_o, busy_o, done_o}), '0);
         chk("reset_skew_word", skew_word_o, '0);
         exp_addr_q.delete();
         exp_word_q.delete();
         ph  = 0;
         rem = 0;
      end else begin
         chk("busy", WW'(busy_o), WW'(ph == 1));
         chk("done", WW'(done_o), WW'(ph == 2));
         if (rd_en_o) begin
            rd_cnt++;
            if (exp_addr_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_read: got addr %h expected none at %0t", rd_addr_o, $time);
            end else chk("rd_addr", WW'(rd_addr_o), WW'(exp_addr_q.pop_front()));
         end
         if (skew_en_o) begin
            skew_cnt++;
            if (exp_word_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_skew: got %h expected none at %0t", skew_word_o, $time);
            end else chk("skew_word", skew_word_o, exp_word_q.pop_front());
         end else chk("skew_word_idle", skew_word_o, '0);
         if (stall_i) chk("stall_quiet", WW'({rd_en_o, skew_en_o}), '0);
         if (done_o) done_cnt++;
         case (ph)
            0: if (start_i) begin
               if (len_i == '0) ph = 2;
               else begin
                  rem = int'(len_i) + SKEW_DEPTH + 1;
                  ph  = 1;
               end
            end
            1: begin
               if (!stall_i) rem--;
               if (rem == 0) ph = 2;
            end
            default: ph = 0;
         endcase
      end
   end

   // mode 0: no stall, 1: random stall, 2: stall cycles s0..s0+k-1 after start.
   task automatic run_op(input logic [AW-1:0] base, input int len, input int mode,
                         input int s0, input int k, input bit extra_start, input int rst_at);
      int  rd0, sk0, d0, bound;
      bit  got_done, aborted;
      logic [AW-1:0] a;
      @(posedge clk_i); #1;
      base_addr_i = base;
      len_i       = LW'(len);
      start_i     = 1'b1;
      stall_i     = 1'b0;
      for (int i = 0; i < len; i++) begin
         a = base + AW'(i);
         exp_addr_q.push_back(a);
         exp_word_q.push_back(mem[a]);
      end
      if (len > 0) for (int i = 0; i < SKEW_DEPTH; i++) exp_word_q.push_back('0);
      rd0 = rd_cnt; sk0 = skew_cnt;
      got_done = 1'b0; aborted = 1'b0;
      bound = 2 * len + 200;
      for (int c = 1; c <= bound && !got_done && !aborted; c++) begin
         @(posedge clk_i); #1;
         start_i = extra_start && (c == 2);
         if (start_i) begin
            len_i       = LW'($urandom_range(1, 8));
            base_addr_i = AW'($urandom());
         end
         case (mode)
            1:       stall_i = ($urandom_range(0, 3) == 0);
            2:       stall_i = (c >= s0) && (c < s0 + k);
            default: stall_i = 1'b0;
         endcase
         if (c == rst_at) begin
            rst_ni = 1'b0;
            #1;
            chk("reset_async", WW'({rd_en_o, rd_addr_o, skew_en_o, busy_o, done_o, |skew_word_o}), '0);
            d0 = done_cnt;
            repeat (3) @(posedge clk_i);
            #1;
            rst_ni  = 1'b1;
            stall_i = 1'b0;
            start_i = 1'b0;
            repeat (4) @(posedge clk_i);
            #1;
            chk("no_done_after_reset", WW'(done_cnt), WW'(d0));
            aborted = 1'b1;
         end else if (done_o) got_done = 1'b1;
      end
      start_i = 1'b0;
      stall_i = 1'b0;
      if (!aborted) begin
         if (!got_done) begin
            tests++; fails++;
            $display("FAIL op_timeout: got no done_o within %0d cycles, expected done (len %0d)", bound, len);
         end else begin
            chk("read_count", WW'(rd_cnt - rd0), WW'(len));
            chk("skew_count", WW'(skew_cnt - sk0), WW'(len == 0 ? 0 : len + SKEW_DEPTH));
            chk("words_drained", WW'(exp_word_q.size()), '0);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, len;
      for (int i = 0; i < DEPTH; i++) mem[i] = rand_word();
      rst_ni = 1'b0; start_i = 1'b0; stall_i = 1'b0;
      base_addr_i = '0; len_i = '0;
      repeat (3) @(posedge clk_i);
      #1;
      chk("reset_state", WW'({rd_en_o, rd_addr_o, skew_en_o, busy_o, done_o, |skew_word_o}), '0);
      rst_ni = 1'b1;

      run_op(8'h10, 3, 0, 0, 0, 1'b0, -1);
      run_op(AW'($urandom()), 4, 2, 3, 2, 1'b0, -1);
      d0 = done_cnt;
      run_op(AW'($urandom()), 0, 0, 0, 0, 1'b0, -1);
      run_op(AW'($urandom()), 6, 0, 0, 0, 1'b1, -1);
      chk("done_count", WW'(done_cnt - d0), WW'(2));
      run_op(8'hFE, 4, 0, 0, 0, 1'b0, -1);
      run_op(AW'($urandom()), 256, 0, 0, 0, 1'b0, -1);
      run_op(AW'($urandom()), 5, 0, 0, 0, 1'b0, 10);
      run_op(AW'($urandom()), 3, 0, 0, 0, 1'b0, -1);
      run_op(AW'($urandom()), 3, 2, 8, 3, 1'b0, -1);
      for (int n = 0; n < 24; n++) begin
         len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 256)) : int'($urandom_range(0, 20));
         run_op(AW'($urandom()), len, 1, 0, 0, 1'b0, -1);
      end

      repeat (2) @(posedge clk_i);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
